// File: rtl/fault_mem_cfg_if.sv
// Access and fault-configuration bus of the configurable faulty SRAM model.
// The master drives accesses and configuration; the memory returns read data and fault activity.
interface fault_mem_cfg_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int BIT_W      = $clog2(DATA_WIDTH)
);
  logic                  write_read;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  cfg_we;
  logic [2:0]            cfg_type;
  logic [ADDR_WIDTH-1:0] cfg_victim;
  logic [ADDR_WIDTH-1:0] cfg_aggr;
  logic [BIT_W-1:0]      cfg_bit;
  logic                  cfg_pol;
  logic                  fault_hit;
  logic [15:0]           hit_cnt;

  modport master (
    output write_read, address, wdata, cfg_we, cfg_type, cfg_victim, cfg_aggr, cfg_bit, cfg_pol,
    input  rdata, fault_hit, hit_cnt
  );
  modport slave (
    input  write_read, address, wdata, cfg_we, cfg_type, cfg_victim, cfg_aggr, cfg_bit, cfg_pol,
    output rdata, fault_hit, hit_cnt
  );
endinterface

// File: rtl/fault_mem_cfg.sv
// Single-port SRAM model with one runtime-programmable fault (stuck-at, transition, coupling, NPSF).
// Define FAULT_MEM_HIT_CNT_EN to build the saturating activation counter; otherwise hit_cnt is 0.
module fault_mem_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int BIT_W      = $clog2(DATA_WIDTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  fault_mem_cfg_if.slave  bus
);
  typedef enum logic [2:0] {
    F_NONE = 3'd0, F_STUCK = 3'd1, F_TRANS = 3'd2, F_COUPLE = 3'd3, F_NPSF = 3'd4
  } fault_e;

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] wdata_q, wr_word, rd_word;
  fault_e                c_type;
  logic [ADDR_WIDTH-1:0] c_victim, c_aggr, rd_addr;
  logic [BIT_W-1:0]      c_bit;
  logic                  c_pol;
  logic                  rd_vld, rd_ok;
  logic                  addr_ok, wr_en, vic_ok, act, flip_vic;
  logic                  cur_bit, nb_lo, nb_hi;

  assign addr_ok = {1'b0, bus.address} < DEPTH_L;
  assign vic_ok  = {1'b0, c_victim} < DEPTH_L;
  assign wr_en   = bus.write_read && addr_ok;

  // Fault effect on the word being written; coupling also flips the victim bit on the same edge.
  always_comb begin
    wr_word  = wdata_q;
    act      = 1'b0;
    flip_vic = 1'b0;
    cur_bit  = mem[bus.address][c_bit];
    nb_lo    = (c_victim == '0) ? ~c_pol : mem[c_victim - ADDR_WIDTH'(1)][c_bit];
    nb_hi    = (({1'b0, c_victim} + (ADDR_WIDTH+1)'(1)) < DEPTH_L)
               ? mem[c_victim + ADDR_WIDTH'(1)][c_bit] : ~c_pol;
    if (wr_en) begin
      case (c_type)
        F_STUCK: if (bus.address == c_victim) begin
          wr_word[c_bit] = c_pol;
          act            = (wdata_q[c_bit] != c_pol);
        end
        F_TRANS: if (bus.address == c_victim && cur_bit == ~c_pol && wdata_q[c_bit] == c_pol) begin
          wr_word[c_bit] = ~c_pol;
          act            = 1'b1;
        end
        F_COUPLE: if (bus.address == c_aggr && c_aggr != c_victim && vic_ok &&
                      cur_bit != wdata_q[c_bit]) begin
          flip_vic = 1'b1;
          act      = 1'b1;
        end
        F_NPSF: if (bus.address == c_victim && nb_lo == ~c_pol && nb_hi == ~c_pol) begin
          wr_word[c_bit] = ~c_pol;
          act            = (wdata_q[c_bit] == c_pol);
        end
        default: ;
      endcase
    end
  end

  // A stuck-at victim also reads forced, so never-written contents still show the fault.
  always_comb begin
    rd_word = mem[rd_addr];
    if (c_type == F_STUCK && rd_addr == c_victim) rd_word[c_bit] = c_pol;
  end

  always_ff @(posedge clk) begin
    if (wr_en)    mem[bus.address] <= wr_word;
    if (flip_vic) mem[c_victim][c_bit] <= ~mem[c_victim][c_bit];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdata_q       <= '0;
      rd_vld        <= 1'b0;
      rd_ok         <= 1'b0;
      rd_addr       <= '0;
      bus.rdata     <= '0;
      bus.fault_hit <= 1'b0;
      c_type        <= F_NONE;
      c_victim      <= '0;
      c_aggr        <= '0;
      c_bit         <= '0;
      c_pol         <= 1'b0;
    end else begin
      wdata_q       <= bus.wdata;
      rd_vld        <= !bus.write_read;
      rd_ok         <= addr_ok;
      rd_addr       <= bus.address;
      bus.fault_hit <= act;
      if (rd_vld) bus.rdata <= rd_ok ? rd_word : '0;
      if (bus.cfg_we) begin
        c_type   <= fault_e'(bus.cfg_type);
        c_victim <= bus.cfg_victim;
        c_aggr   <= bus.cfg_aggr;
        c_bit    <= bus.cfg_bit;
        c_pol    <= bus.cfg_pol;
      end
    end
  end

`ifdef FAULT_MEM_HIT_CNT_EN
  logic [15:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       cnt <= '0;
    else if (bus.cfg_we)              cnt <= '0;
    else if (act && cnt != 16'hFFFF)  cnt <= cnt + 16'd1;
  end
  assign bus.hit_cnt = cnt;
`else
  assign bus.hit_cnt = '0;
`endif
endmodule

// File: tb/tb_fault_mem_cfg.sv
// Scenario bench for fault_mem_cfg: one task per fault type plus reset, range and streaming cases.
module tb_fault_mem_cfg;
  localparam int DW = 8, AW = 4, DEPTH = 12;
`ifdef FAULT_MEM_HIT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  int errors = 0, checks = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] e;

  fault_mem_cfg_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
  fault_mem_cfg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [15:0] cnt_exp(input int n);
    return CNT_EN ? 16'(n) : 16'h0;
  endfunction

  task automatic set_cfg(input logic [2:0] t, input logic [AW-1:0] v, input logic [AW-1:0] a,
                         input logic [2:0] b, input logic p);
    @(negedge clk);
    bus.write_read = 1'b0; bus.cfg_we = 1'b1; bus.cfg_type = t;
    bus.cfg_victim = v; bus.cfg_aggr = a; bus.cfg_bit = b; bus.cfg_pol = p;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  // Returns on the negedge right after the write edge, where fault_hit shows that write.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk); bus.write_read = 1'b0; bus.address = a; bus.wdata = d;
    @(negedge clk); bus.write_read = 1'b1;
    @(negedge clk); bus.write_read = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] x);
    @(negedge clk); bus.write_read = 1'b0; bus.address = a; exp_q.push_back(x);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.write_read = 1'b0; bus.address = '0; bus.wdata = '0; bus.cfg_we = 1'b0;
    bus.cfg_type = '0; bus.cfg_victim = '0; bus.cfg_aggr = '0; bus.cfg_bit = '0; bus.cfg_pol = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", bus.rdata); end
    checks++; if (bus.fault_hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", bus.fault_hit); end
    checks++; if (bus.hit_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", bus.hit_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_no_fault();
    do_write(4'd3, 8'hA5);
    checks++; if (bus.fault_hit !== 1'b0) begin errors++; $display("FAIL none_hit_wr: got %b want 0", bus.fault_hit); end
    do_read(4'd3, 8'hA5);
    e = exp_q.pop_front();
    checks++; if (bus.rdata !== e) begin errors++; $display("FAIL none_rd: got %h want %h", bus.rdata, e); end
    checks++; if (bus.fault_hit !== 1'b0) begin errors++; $display("FAIL none_hit_rd: got %b want 0", bus.fault_hit); end
  endtask

  task automatic test_stuck_at();
    set_cfg(3'd1, 4'd5, 4'd0, 3'd2, 1'b0);
    do_write(4'd5, 8'hFF);
    checks++; if (bus.fault_hit !== 1'b1) begin errors++; $display("FAIL sa_hit: got %b want 1", bus.fault_hit); end
    checks++; if (bus.hit_cnt !== cnt_exp(1)) begin errors++; $display("FAIL sa_cnt: got %h want %h", bus.hit_cnt, cnt_exp(1)); end
    do_read(4'd5, 8'hFB);
    e = exp_q.pop_front();
    checks++; if (bus.rdata !== e) begin errors++; $display("FAIL sa_rd: got %h want %h", bus.rdata, e); end
    do_write(4'd5, 8'hFB);
    checks++; if (bus.fault_hit !== 1'b0) begin errors++; $display("FAIL sa_nohit: got %b want 0", bus.fault_hit); end
  endtask

  task automatic test_transition();
    set_cfg(3'd2, 4'd7, 4'd0, 3'd0, 1'b1);
    do_write(4'd7, 8'h00);
    do_write(4'd7, 8'h01);
    checks++; if (bus.fault_hit !== 1'b1) begin errors++; $display("FAIL tf_hit: got %b want 1", bus.fault_hit); end
    checks++; if (bus.hit_cnt !== cnt_exp(1)) begin errors++; $display("FAIL tf_cnt1: got %h want %h", bus.hit_cnt, cnt_exp(1)); end
    do_read(4'd7, 8'h00);
    e = exp_q.pop_front();
    checks++; if (bus.rdata !== e) begin errors++; $display("FAIL tf_rd: got %h want %h", bus.rdata, e); end
    do_write(4'd7, 8'h01);
    checks++; if (bus.hit_cnt !== cnt_exp(2)) begin errors++; $display("FAIL tf_cnt2: got %h want %h", bus.hit_cnt, cnt_exp(2)); end
  endtask

  task automatic test_coupling();
    do_write(4'd2, 8'h00);
    set_cfg(3'd3, 4'd9, 4'd2, 3'd1, 1'b0);
    do_write(4'd9, 8'h00);
    do_write(4'd2, 8'h00);
    checks++; if (bus.fault_hit !== 1'b0) begin errors++; $display("FAIL cf_same: got %b want 0", bus.fault_hit); end
    do_write(4'd2, 8'h02);
    checks++; if (bus.fault_hit !== 1'b1) begin errors++; $display("FAIL cf_hit: got %b want 1", bus.fault_hit); end
    do_read(4'd9, 8'h02);
    e = exp_q.pop_front();
    checks++; if (bus.rdata !== e) begin errors++; $display("FAIL cf_victim: got %h want %h", bus.rdata, e); end
    do_write(4'd2, 8'h02);
    checks++; if (bus.fault_hit !== 1'b0) begin errors++; $display("FAIL cf_rewrite: got %b want 0", bus.fault_hit); end
    checks++; if (bus.hit_cnt !== cnt_exp(1)) begin errors++; $display("FAIL cf_cnt: got %h want %h", bus.hit_cnt, cnt_exp(1)); end
    do_read(4'd2, 8'h02);
    e = exp_q.pop_front();
    checks++; if (bus.rdata !== e) begin errors++; $display("FAIL cf_aggr: got %h want %h", bus.rdata, e); end
  endtask

  task automatic test_npsf();
    set_cfg(3'd4, 4'd0, 4'd0, 3'd1, 1'b1);
    do_write(4'd1, 8'h00);
    do_write(4'd0, 8'hFF);
    checks++; if (bus.fault_hit !== 1'b1) begin errors++; $display("FAIL np_hit: got %b want 1", bus.fault_hit); end
    do_read(4'd0, 8'hFD);
    e = exp_q.pop_front();
    checks++; if (bus.rdata !== e) begin errors++; $display("FAIL np_rd: got %h want %h", bus.rdata, e); end
    do_write(4'd1, 8'h02);
    do_write(4'd0, 8'hFF);
    checks++; if (bus.fault_hit !== 1'b0) begin errors++; $display("FAIL np_nohit: got %b want 0", bus.fault_hit); end
    do_read(4'd0, 8'hFF);
    e = exp_q.pop_front();
    checks++; if (bus.rdata !== e) begin errors++; $display("FAIL np_rd2: got %h want %h", bus.rdata, e); end
    // Top-edge victim: the missing upper neighbour counts as ~pol.
    set_cfg(3'd4, 4'(DEPTH-1), 4'd0, 3'd0, 1'b0);
    do_write(4'(DEPTH-2), 8'h01);
    do_write(4'(DEPTH-1), 8'h00);
    checks++; if (bus.fault_hit !== 1'b1) begin errors++; $display("FAIL np_top_hit: got %b want 1", bus.fault_hit); end
    do_read(4'(DEPTH-1), 8'h01);
    e = exp_q.pop_front();
    checks++; if (bus.rdata !== e) begin errors++; $display("FAIL np_top_rd: got %h want %h", bus.rdata, e); end
  endtask

  task automatic test_out_of_range();
    set_cfg(3'd0, 4'd0, 4'd0, 3'd0, 1'b0);
    do_write(4'd13, 8'h5A);
    do_read(4'd13, 8'h00);
    e = exp_q.pop_front();
    checks++; if (bus.rdata !== e) begin errors++; $display("FAIL oor_rd13: got %h want %h", bus.rdata, e); end
    do_read(4'(DEPTH), 8'h00);
    e = exp_q.pop_front();
    checks++; if (bus.rdata !== e) begin errors++; $display("FAIL oor_rd_depth: got %h want %h", bus.rdata, e); end
    do_read(4'd1, 8'h02);
    e = exp_q.pop_front();
    checks++; if (bus.rdata !== e) begin errors++; $display("FAIL oor_alias: got %h want %h", bus.rdata, e); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d[5];
    for (int i = 0; i < 5; i++) d[i] = DW'($urandom);
    // Streamed writes: wdata for word i leads its strobe by one cycle.
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      bus.wdata      = (i < 5) ? d[i] : '0;
      bus.write_read = (i > 0);
      bus.address    = AW'(3 + i);
    end
    // Streamed reads, newest word first so the first read follows the last write directly.
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      if (t >= 2) begin
        e = exp_q.pop_front();
        checks++; if (bus.rdata !== e) begin errors++; $display("FAIL b2b_rd%0d: got %h want %h", t - 2, bus.rdata, e); end
      end
      if (t < 5) begin
        bus.write_read = 1'b0;
        bus.address    = AW'(8 - t);
        exp_q.push_back(d[4 - t]);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    set_cfg(3'd1, 4'd6, 4'd0, 3'd0, 1'b1);
    do_write(4'd6, 8'h00);
    @(negedge clk);
    bus.wdata = 8'hFF;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h want 00", bus.rdata); end
    checks++; if (bus.fault_hit !== 1'b0) begin errors++; $display("FAIL rst_hit: got %b want 0", bus.fault_hit); end
    @(posedge clk); #1;
    checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL rst_inflight: got %h want 00", bus.rdata); end
    @(negedge clk);
    rst_n = 1'b1; bus.write_read = 1'b1; bus.address = 4'd6;
    @(negedge clk);
    bus.write_read = 1'b0;
    checks++; if (bus.fault_hit !== 1'b0) begin errors++; $display("FAIL rst_cfg_hit: got %b want 0", bus.fault_hit); end
    exp_q.push_back(8'h00);
    repeat (2) @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (bus.rdata !== e) begin errors++; $display("FAIL rst_first_wr: got %h want %h", bus.rdata, e); end
    checks++; if (bus.hit_cnt !== 16'h0) begin errors++; $display("FAIL rst_cnt: got %h want 0", bus.hit_cnt); end
  endtask

  initial begin
    test_reset();
    test_no_fault();
    test_stuck_at();
    test_transition();
    test_coupling();
    test_npsf();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
